// File: rtl/sqrt_collector_pkg.sv
// Package: sqrt_collector_pkg
// Shared sizing constants, types and a small helper for the sqrt result
// collector slice (sqrt_collector_lane, sqrt_result_collector).
//
// Contents:
//   SQRT_LANES  default number of worker lanes (round-robin modulus)
//   SQRT_W      default result width in bits
//   sqrt_res_t  one result word
//   lane_idx_t  lane index wide enough for SQRT_LANES lanes
//   next_lane() round-robin successor of a lane index
package sqrt_collector_pkg;

    localparam int SQRT_LANES = 50;
    localparam int SQRT_W     = 32;

    typedef logic [SQRT_W-1:0]             sqrt_res_t;
    typedef logic [$clog2(SQRT_LANES)-1:0] lane_idx_t;

    // Round-robin successor; wraps to 0 after the last lane.
    function automatic int next_lane(input int cur, input int lanes);
        return (cur == lanes - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sqrt_collector_lane.sv
// Module: sqrt_collector_lane
// One-entry holding buffer for a single worker lane of the sqrt result
// collector. Captures a worker result, keeps it until the collector drains
// it, and flags a result that arrives while the buffer is still occupied.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   in_vld  in   worker result strobe (single-cycle pulse)
//   in_res  in   worker result, valid with in_vld
//   drain   in   collector takes the held result this cycle
//   full    out  buffer holds an undrained result
//   data    out  held result
//   ovf     out  combinational: in_vld hit a full buffer that is not draining
module sqrt_collector_lane
    import sqrt_collector_pkg::*;
#(
    parameter int W = SQRT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_res,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] data,
    output logic         ovf
);

    // A drain in the same cycle frees the slot, so a new result may land
    // in it directly and the buffer stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (in_vld && (!full || drain)) begin
                data <= in_res;
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

    // The incoming result is lost; the top level makes this sticky.
    assign ovf = in_vld & full & ~drain;

endmodule

// File: rtl/sqrt_result_collector.sv
// Module: sqrt_result_collector
// Return end of the sqrt formula fan-out. Collects results from N worker
// lanes that complete out of order and re-emits them strictly in round-robin
// dispatch order (lane 0, 1, ..., N-1, 0, ...) on one valid/ready stream.
//
// Build option: define SQRT_COLLECTOR_BYPASS_EN to let a result arriving on
// the lane currently at the head go straight into the output register
// (1-cycle latency) when that lane's buffer is empty and the output can load.
// Without it every result passes through its lane buffer (2-cycle latency).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   lane_vld   in   [N]   per-lane result strobe
//   lane_res   in   [N*W] per-lane result, lane i at [i*W +: W]
//   lane_free  out  [N]   lane i buffer empty; worker i may be dispatched
//   res_vld    out  output result valid
//   res_rdy    in   downstream accepts the result
//   res        out  [W]   output result
//   ovf_err    out  sticky: a result arrived on a full lane and was dropped
module sqrt_result_collector
    import sqrt_collector_pkg::*;
#(
    parameter int N = SQRT_LANES,
    parameter int W = SQRT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   lane_vld,
    input  logic [N*W-1:0] lane_res,
    output logic [N-1:0]   lane_free,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [W-1:0]   res,
    output logic           ovf_err
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;

    logic [N-1:0]  hold_full;
    logic [N-1:0]  lane_ovf;
    logic [N-1:0]  lane_in_vld;
    logic [N-1:0]  drain_vec;
    logic [W-1:0]  hold_data [N];

    logic          out_ok;
    logic          head_full;
    logic [W-1:0]  head_data;
    logic          drain_take;
    logic          bypass_take;
    logic          load;
    logic [W-1:0]  load_data;

`ifdef SQRT_COLLECTOR_BYPASS_EN
    logic [W-1:0]  bypass_data;
`endif

    // Per-lane holding buffers.
    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            sqrt_collector_lane #(
                .W (W)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .in_vld (lane_in_vld[g]),
                .in_res (lane_res[g*W +: W]),
                .drain  (drain_vec[g]),
                .full   (hold_full[g]),
                .data   (hold_data[g]),
                .ovf    (lane_ovf[g])
            );
        end
    endgenerate

    assign lane_free = ~hold_full;

    assign out_ok     = ~res_vld | res_rdy;
    assign head_full  = hold_full[rd_ptr];
    assign head_data  = hold_data[rd_ptr];
    assign rd_ptr_nxt = PW'(next_lane(int'(rd_ptr), N));

    // Only the head lane can be drained. A bypassed result never touches
    // its hold register, so its strobe is masked off from the lane buffer.
    always_comb begin
        drain_take  = out_ok & head_full;
        bypass_take = 1'b0;
        load_data   = head_data;
`ifdef SQRT_COLLECTOR_BYPASS_EN
        bypass_data = lane_res[rd_ptr*W +: W];
        bypass_take = out_ok & ~head_full & lane_vld[rd_ptr];
        if (bypass_take) begin
            load_data = bypass_data;
        end
`endif
        load        = drain_take | bypass_take;

        drain_vec   = '0;
        if (drain_take) begin
            drain_vec[rd_ptr] = 1'b1;
        end

        lane_in_vld = lane_vld;
        if (bypass_take) begin
            lane_in_vld[rd_ptr] = 1'b0;
        end
    end

    // Output register and read pointer. A valid result is held unchanged
    // while the downstream stalls; it is never retracted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            res_vld <= 1'b0;
            res     <= '0;
            ovf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err | (|lane_ovf);
            if (load) begin
                res     <= load_data;
                res_vld <= 1'b1;
                rd_ptr  <= rd_ptr_nxt;
            end else if (res_vld && res_rdy) begin
                res_vld <= 1'b0;
            end
        end
    end

endmodule
